bp_me_mem_port_arbiter: RTL and testbench
=========================================

// Module: bp_me_mem_port_arbiter
// PURPOSE
//  Shares one BedRock memory port (bp_nonsynth_mem cmd/resp) among num_req_p
//  cache engines (UCE or CCE per dcache instance) in the multi-cache D$ bench.
//  Round-robin arbitrates single-beat mem commands and records the winner ID.
//  Routes in-order memory responses back to the issuing requester.
// PARAMETERS
//  num_req_p        2    number of requesters (1..8)
//  mem_msg_width_p  640  width of packed bp_bedrock_cce_mem_msg_s (header+block)
//  outstanding_p    4    max in-flight cmds; depth of response-routing ID FIFO (pow2)
// PORTS
//  clk_i             in   1                          clock
//  reset_i           in   1                          async reset, active-low
//  req_cmd_i         in   num_req_p*mem_msg_width_p  per-requester mem cmd
//  req_cmd_v_i       in   num_req_p                  cmd valid
//  req_cmd_ready_and_o out num_req_p                 cmd ready (ready&valid handshake)
//  req_resp_o        out  num_req_p*mem_msg_width_p  mem resp, broadcast to all
//  req_resp_v_o      out  num_req_p                  resp valid, one-hot to owner
//  req_resp_yumi_i   in   num_req_p                  resp consumed
//  mem_cmd_o         out  mem_msg_width_p            cmd to memory
//  mem_cmd_v_o       out  1                          cmd valid
//  mem_cmd_ready_and_i in 1                          memory accepts cmd
//  mem_resp_i        in   mem_msg_width_p            resp from memory
//  mem_resp_v_i      in   1                          resp valid
//  mem_resp_yumi_o   out  1                          resp consumed
//  error_o           out  1                          sticky: orphan response seen
// BEHAVIOUR
//  Reset (reset_i==0, async): rr_ptr=0, ID FIFO empty, error_o=0; all valid/ready
//   outputs 0 while held and on the first cycle after release (no cmd passes).
//  Arbitration (combinational, same cycle):
//   - eligible = req_cmd_v_i & {num_req_p{~fifo_full}}.
//   - winner = first eligible index scanning rr_ptr, rr_ptr+1, ... mod num_req_p.
//   - mem_cmd_v_o = |eligible; mem_cmd_o = req_cmd_i[winner].
//   - req_cmd_ready_and_o[winner] = mem_cmd_ready_and_i & ~fifo_full; others 0.
//   - mem_cmd_v_o never depends on mem_cmd_ready_and_i.
//  On cmd handshake (mem_cmd_v_o & mem_cmd_ready_and_i): enqueue winner ID;
//   rr_ptr <= winner+1 (wrap to 0 at num_req_p). No handshake: rr_ptr holds.
//  Full: enqueue blocked when count==outstanding_p, even if a dequeue happens
//   the same cycle (cmd accepted next cycle at earliest).
//  Response routing (combinational):
//   - owner = ID FIFO head; req_resp_o[i] = mem_resp_i for all i.
//   - req_resp_v_o[owner] = mem_resp_v_i & ~fifo_empty.
//   - mem_resp_yumi_o = req_resp_yumi_i[owner] & req_resp_v_o[owner]; pop FIFO on it.
//   - yumi from non-owner requester ignored.
//  Empty: mem_resp_v_i with FIFO empty -> no req_resp_v_o, mem_resp_yumi_o=0,
//   error_o <= 1 and holds until reset.
//  Simultaneous enqueue+dequeue (not full): count unchanged, both take effect.
//  Counter/pointer widths: count $clog2(outstanding_p)+1 bits; FIFO pointers wrap mod depth.
//  Memory returns responses in command order; no reordering supported.
//  Reset mid-operation: in-flight IDs discarded, outputs drop asynchronously.
// TESTING
//  1 req0 only, 3 cmds, mem ready -> 3 handshakes, resps to req0, rr_ptr=1 after each.
//  2 req0,req1 both valid continuously -> grants alternate 0,1,0,1; resps same order.
//  3 mem_resp stalled, 5 cmds offered, outstanding_p=4 -> 4 accepted, 5th held until 1st resp yumi.
//  4 full + resp yumi same cycle -> no enqueue that cycle; cmd accepted next cycle.
//  5 mem_resp_v_i with FIFO empty -> req_resp_v_o=0, mem_resp_yumi_o=0, error_o=1 sticky.
//  6 reset_i low with 2 in flight -> outputs 0 immediately; after release FIFO empty, rr_ptr=0.

Source files
------------

// File: rtl/bp_me_mem_port_arbiter.sv
// Shares one BedRock memory port among num_req_p cache engines.
// Single-beat commands are round-robin arbitrated; the winner ID is queued
// so that in-order memory responses can be routed back to their issuer.
module bp_me_mem_port_arbiter #(
    parameter int unsigned num_req_p       = 2,
    parameter int unsigned mem_msg_width_p = 640,
    parameter int unsigned outstanding_p   = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [num_req_p*mem_msg_width_p-1:0]   req_cmd_i,
    input  logic [num_req_p-1:0]                   req_cmd_v_i,
    output logic [num_req_p-1:0]                   req_cmd_ready_and_o,

    output logic [num_req_p*mem_msg_width_p-1:0]   req_resp_o,
    output logic [num_req_p-1:0]                   req_resp_v_o,
    input  logic [num_req_p-1:0]                   req_resp_yumi_i,

    output logic [mem_msg_width_p-1:0]             mem_cmd_o,
    output logic                                   mem_cmd_v_o,
    input  logic                                   mem_cmd_ready_and_i,

    input  logic [mem_msg_width_p-1:0]             mem_resp_i,
    input  logic                                   mem_resp_v_i,
    output logic                                   mem_resp_yumi_o,

    output logic                                   error_o
);

    localparam int unsigned id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned ptr_w_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(outstanding_p) + 1;

    localparam logic [id_w_lp-1:0]  last_id_lp   = id_w_lp'(num_req_p - 1);
    localparam logic [ptr_w_lp-1:0] last_slot_lp = ptr_w_lp'(outstanding_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp  = cnt_w_lp'(outstanding_p);

    logic                active_q;
    logic [id_w_lp-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [ptr_w_lp-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q,  rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q,   count_d;
    logic                error_q,   error_d;
    logic [id_w_lp-1:0]  fifo_q [outstanding_p];

    logic                 fifo_full, fifo_empty;
    logic [num_req_p-1:0] eligible;
    logic [id_w_lp-1:0]   winner;
    logic                 found;
    logic                 cmd_hs;
    logic [id_w_lp-1:0]   owner;
    logic                 resp_v;

    assign fifo_full  = (count_q == full_cnt_lp);
    assign fifo_empty = (count_q == '0);
    assign owner      = fifo_q[rd_ptr_q];
    assign req_resp_o = {num_req_p{mem_resp_i}};
    assign error_o    = error_q;

    // Round-robin arbitration; active_q keeps every handshake closed during
    // reset and on the first cycle after release.
    always_comb begin
        eligible = req_cmd_v_i & {num_req_p{~fifo_full & active_q}};
        winner   = rr_ptr_q;
        found    = 1'b0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            int unsigned cand;
            cand = 32'(rr_ptr_q) + i;
            if (cand >= num_req_p) cand = cand - num_req_p;
            if (!found && eligible[cand[id_w_lp-1:0]]) begin
                found  = 1'b1;
                winner = cand[id_w_lp-1:0];
            end
        end
        mem_cmd_v_o         = found;
        mem_cmd_o           = req_cmd_i[winner*mem_msg_width_p +: mem_msg_width_p];
        req_cmd_ready_and_o = '0;
        if (found && mem_cmd_ready_and_i) req_cmd_ready_and_o[winner] = 1'b1;
        cmd_hs              = found & mem_cmd_ready_and_i;
    end

    // Response routing to the head-of-queue owner, plus next-state for all state.
    always_comb begin
        resp_v          = active_q & mem_resp_v_i & ~fifo_empty;
        req_resp_v_o    = '0;
        if (resp_v) req_resp_v_o[owner] = 1'b1;
        mem_resp_yumi_o = resp_v & req_resp_yumi_i[owner];

        rr_ptr_d = rr_ptr_q;
        if (cmd_hs) rr_ptr_d = (winner == last_id_lp) ? '0 : winner + 1'b1;

        wr_ptr_d = wr_ptr_q;
        if (cmd_hs) wr_ptr_d = (wr_ptr_q == last_slot_lp) ? '0 : wr_ptr_q + 1'b1;

        rd_ptr_d = rd_ptr_q;
        if (mem_resp_yumi_o) rd_ptr_d = (rd_ptr_q == last_slot_lp) ? '0 : rd_ptr_q + 1'b1;

        count_d = count_q + cnt_w_lp'(cmd_hs) - cnt_w_lp'(mem_resp_yumi_o);
        error_d = error_q | (active_q & mem_resp_v_i & fifo_empty);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            active_q <= 1'b0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            active_q <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // ID storage; validity is tracked by count_q so entries need no reset.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) fifo_q[wr_ptr_q] <= winner;
    end

endmodule

// File: tb/tb_bp_me_mem_port_arbiter.sv
// Scoreboard bench for bp_me_mem_port_arbiter: two requesters, 16-bit messages,
// four outstanding commands. Memory model answers each command with its
// bitwise complement, in order.
module tb_bp_me_mem_port_arbiter;

    localparam int N   = 2;
    localparam int W   = 16;
    localparam int OUT = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] req_cmd = '0;
    logic [N-1:0]   req_cmd_v = '0;
    logic [N-1:0]   req_cmd_ready;
    logic [N*W-1:0] req_resp;
    logic [N-1:0]   req_resp_v;
    logic [N-1:0]   req_resp_yumi = '0;
    logic [W-1:0]   mem_cmd;
    logic           mem_cmd_v;
    logic           mem_cmd_ready = 1'b0;
    logic [W-1:0]   mem_resp = '0;
    logic           mem_resp_v = 1'b0;
    logic           mem_resp_yumi;
    logic           error;

    bp_me_mem_port_arbiter #(
        .num_req_p(N),
        .mem_msg_width_p(W),
        .outstanding_p(OUT)
    ) dut (
        .clk_i(clk),
        .reset_i(rst_n),
        .req_cmd_i(req_cmd),
        .req_cmd_v_i(req_cmd_v),
        .req_cmd_ready_and_o(req_cmd_ready),
        .req_resp_o(req_resp),
        .req_resp_v_o(req_resp_v),
        .req_resp_yumi_i(req_resp_yumi),
        .mem_cmd_o(mem_cmd),
        .mem_cmd_v_o(mem_cmd_v),
        .mem_cmd_ready_and_i(mem_cmd_ready),
        .mem_resp_i(mem_resp),
        .mem_resp_v_i(mem_resp_v),
        .mem_resp_yumi_o(mem_resp_yumi),
        .error_o(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Requester sources, memory pending list, scoreboard queues ({owner, payload}).
    logic [W-1:0] src0[$];
    logic [W-1:0] src1[$];
    logic [W-1:0] pend[$];
    logic [W:0]   exp_cmd_q[$];
    logic [W:0]   exp_resp_q[$];
    logic [W:0]   e_cmd, e_resp;
    logic [W-1:0] e_data;
    bit take0, take1, taking;
    bit resp_en = 1'b1;
    bit yumi_en = 1'b1;
    bit orphan  = 1'b0;
    int hs_cnt  = 0;

    // Requester drivers: present queue heads, pop after an accepted handshake.
    always @(posedge clk) begin
        #1;
        if (take0 && src0.size() != 0) void'(src0.pop_front());
        if (take1 && src1.size() != 0) void'(src1.pop_front());
        req_cmd_v[0]      = (src0.size() != 0);
        req_cmd[W-1:0]    = (src0.size() != 0) ? src0[0] : '0;
        req_cmd_v[1]      = (src1.size() != 0);
        req_cmd[2*W-1:W]  = (src1.size() != 0) ? src1[0] : '0;
    end

    always @(negedge clk) begin
        take0 = req_cmd_v[0] & req_cmd_ready[0];
        take1 = req_cmd_v[1] & req_cmd_ready[1];
    end

    // Memory model: in-order responses; yumi from owner, or from non-owners when held.
    always @(posedge clk) begin
        #1;
        if (taking && pend.size() != 0) void'(pend.pop_front());
        mem_resp_v = orphan || (resp_en && pend.size() != 0);
        mem_resp   = (pend.size() != 0) ? ~pend[0] : '0;
        #1;
        req_resp_yumi = yumi_en ? req_resp_v : ~req_resp_v;
    end

    // Command monitor.
    always @(negedge clk) begin
        if (mem_cmd_v && mem_cmd_ready) begin
            hs_cnt++;
            pend.push_back(mem_cmd);
            if (exp_cmd_q.size() == 0) begin
                check("cmd_unexpected", 64'(exp_cmd_q.size()), 64'd1);
            end else begin
                e_cmd = exp_cmd_q.pop_front();
                check("cmd_data", 64'(mem_cmd), 64'(e_cmd[W-1:0]));
                check("cmd_grant", 64'(req_cmd_ready), e_cmd[W] ? 64'd2 : 64'd1);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        taking = mem_resp_yumi;
        if (mem_resp_yumi) begin
            if (exp_resp_q.size() == 0) begin
                check("resp_unexpected", 64'(exp_resp_q.size()), 64'd1);
            end else begin
                e_resp = exp_resp_q.pop_front();
                e_data = ~e_resp[W-1:0];
                check("resp_v", 64'(req_resp_v), e_resp[W] ? 64'd2 : 64'd1);
                check("resp_data", 64'(e_resp[W] ? req_resp[2*W-1:W] : req_resp[W-1:0]), 64'(e_data));
            end
        end
    end

    task automatic expect_txn(input logic owner, input logic [W-1:0] d);
        exp_cmd_q.push_back({owner, d});
        exp_resp_q.push_back({owner, d});
    endtask

    task automatic send(input logic owner, input logic [W-1:0] d);
        expect_txn(owner, d);
        if (owner) src1.push_back(d);
        else       src0.push_back(d);
    endtask

    task automatic clear_all();
        src0.delete(); src1.delete(); pend.delete();
        exp_cmd_q.delete(); exp_resp_q.delete();
        hs_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        orphan = 1'b0; resp_en = 1'b1; yumi_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (src0.size() == 0 && src1.size() == 0 &&
                exp_cmd_q.size() == 0 && exp_resp_q.size() == 0) break;
        end
        #1;
        check(name, 64'(exp_cmd_q.size() + exp_resp_q.size() + src0.size() + src1.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state; a pending command must not pass while held or on the first cycle.
        mem_cmd_ready = 1'b1;
        send(1'b0, 16'hA001);
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_v", 64'(mem_cmd_v), 64'd0);
        check("rst_ready", 64'(req_cmd_ready), 64'd0);
        check("rst_resp_v", 64'(req_resp_v), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_cycle_cmd_v", 64'(mem_cmd_v), 64'd0);
        check("first_cycle_ready", 64'(req_cmd_ready), 64'd0);

        // Test 1: req0 alone, three commands, then rr_ptr=1 favours req1.
        send(1'b0, 16'hA002);
        send(1'b0, 16'hA003);
        wait_idle("t1_idle");
        send(1'b1, 16'hB001);
        send(1'b0, 16'hA004);
        wait_idle("t1_rr_idle");

        // Test 2: both requesters continuously valid, grants alternate from req0.
        do_reset();
        send(1'b0, 16'hA011);
        send(1'b1, 16'hB011);
        send(1'b0, 16'hA012);
        send(1'b1, 16'hB012);
        wait_idle("t2_idle");

        // Tests 3/4: responses stalled, five commands; full blocks even on a dequeue cycle.
        do_reset();
        resp_en = 1'b0;
        for (int i = 1; i <= 5; i++) send(1'b0, 16'hA020 + 16'(i));
        repeat (10) @(negedge clk);
        #1;
        check("t3_accepted", 64'(hs_cnt), 64'd4);
        check("t3_full_cmd_v", 64'(mem_cmd_v), 64'd0);
        check("t3_full_ready", 64'(req_cmd_ready), 64'd0);
        resp_en = 1'b1;
        @(negedge clk);
        check("t4_yumi", 64'(mem_resp_yumi), 64'd1);
        check("t4_no_enq_cmd_v", 64'(mem_cmd_v), 64'd0);
        check("t4_no_enq_ready", 64'(req_cmd_ready), 64'd0);
        @(negedge clk);
        check("t4_next_cmd_v", 64'(mem_cmd_v), 64'd1);
        check("t4_next_ready", 64'(req_cmd_ready), 64'd1);
        wait_idle("t3_idle");

        // Test 5: orphan response.
        do_reset();
        orphan = 1'b1;
        @(negedge clk);
        check("t5_resp_v", 64'(req_resp_v), 64'd0);
        check("t5_yumi", 64'(mem_resp_yumi), 64'd0);
        orphan = 1'b0;
        @(negedge clk);
        check("t5_error", 64'(error), 64'd1);
        repeat (3) @(negedge clk);
        check("t5_error_sticky", 64'(error), 64'd1);

        // Test 6: reset with two commands in flight.
        do_reset();
        yumi_en = 1'b0;
        send(1'b1, 16'hB031);
        send(1'b1, 16'hB032);
        repeat (6) @(negedge clk);
        #1;
        check("t6_inflight", 64'(hs_cnt), 64'd2);
        check("t6_held_v", 64'(req_resp_v), 64'd2);
        check("t6_nonowner_yumi", 64'(mem_resp_yumi), 64'd0);
        mem_cmd_ready = 1'b0;
        src0.push_back(16'hA031);
        src1.push_back(16'hB033);
        repeat (2) @(negedge clk);
        #1;
        check("t6_pre_cmd_v", 64'(mem_cmd_v), 64'd1);
        rst_n = 1'b0;
        exp_cmd_q.delete(); exp_resp_q.delete(); pend.delete();
        hs_cnt = 0;
        #1;
        check("t6_rst_cmd_v", 64'(mem_cmd_v), 64'd0);
        check("t6_rst_resp_v", 64'(req_resp_v), 64'd0);
        check("t6_rst_ready", 64'(req_cmd_ready), 64'd0);
        expect_txn(1'b0, 16'hA031);
        expect_txn(1'b1, 16'hB033);
        yumi_en = 1'b1;
        mem_cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_first_cycle_cmd_v", 64'(mem_cmd_v), 64'd0);
        wait_idle("t6_idle");
        check("t6_error_clear", 64'(error), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
